// File: rtl/nora_bus_pkg.sv
// Shared types and constants for the CPU bus responder.
// Optional IO stretch is enabled by defining IO_WAIT_EN.
package nora_bus_pkg;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_ROM,
      REG_IO
   } region_t;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      ACTIVE,
      STRETCH
   } state_t;

   localparam logic [15:0] IO_BASE  = 16'h9F00;
   localparam logic [15:0] ROM_BASE = 16'hA000;
   localparam int WAIT_CYCLES_DEF   = 6;

endpackage

// File: rtl/cpubus_addr_dec.sv
// Combinational address decoder: maps a 16-bit CPU address to a region.
import nora_bus_pkg::*;

module cpubus_addr_dec (
   input  logic [15:0] addr,
   output region_t     region
);

   always_comb begin
      region = REG_RAM;
      if (addr >= ROM_BASE) region = REG_ROM;
      else if (addr >= IO_BASE) region = REG_IO;
   end

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: latches address, drives selects and strobes.
// Define IO_WAIT_EN to stretch IO accesses via run and io_wait.
import nora_bus_pkg::*;

module cpu_bus_responder #(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        latch_ad,
   input  logic        setup_cs,
   input  logic        release_wr,
   input  logic        release_cs,
   input  logic        stopped,
   output logic        run,
   input  logic [15:0] cpu_ab,
   input  logic        cpu_rwn,
   input  logic        io_wait,
   output logic        ram_csn,
   output logic        rom_csn,
   output logic        io_csn,
   output logic        mem_rdn,
   output logic        mem_wrn
);

   state_t      state;
   logic [15:0] addr_q;
   logic        rwn_q;
   region_t     region;
   logic        stretch_pend;
   logic        cnt_done;
   logic        abort;

   cpubus_addr_dec u_dec (
      .addr   (addr_q),
      .region (region)
   );

   assign abort = stopped && (state != STRETCH);

`ifdef IO_WAIT_EN
   localparam int CW = $clog2(WAIT_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic          io_start;

   assign io_start     = (state == ADDR) && setup_cs && (region == REG_IO);
   assign stretch_pend = ~run;
   assign cnt_done     = (cnt == '0) && !io_wait;

   always_ff @(posedge clk) begin
      if (!resetn || abort) begin
         cnt <= '0;
         run <= 1'b1;
      end else begin
         if (io_start) cnt <= CW'(WAIT_CYCLES);
         else if (cnt != '0) cnt <= cnt - 1'b1;
         if (io_start) run <= 1'b0;
         else if (state == STRETCH && cnt_done) run <= 1'b1;
      end
   end
`else
   logic unused_io;

   assign unused_io    = io_wait;
   assign stretch_pend = 1'b0;
   assign cnt_done     = 1'b1;
   assign run          = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         addr_q  <= 16'h0000;
         rwn_q   <= 1'b1;
         ram_csn <= 1'b1;
         rom_csn <= 1'b1;
         io_csn  <= 1'b1;
         mem_rdn <= 1'b1;
         mem_wrn <= 1'b1;
      end else if (abort) begin
         state   <= IDLE;
         ram_csn <= 1'b1;
         rom_csn <= 1'b1;
         io_csn  <= 1'b1;
         mem_rdn <= 1'b1;
         mem_wrn <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (latch_ad) begin
                  addr_q <= cpu_ab;
                  rwn_q  <= cpu_rwn;
                  state  <= ADDR;
               end
            end
            ADDR: begin
               if (setup_cs) begin
                  ram_csn <= (region != REG_RAM);
                  rom_csn <= (region != REG_ROM);
                  io_csn  <= (region != REG_IO);
                  mem_rdn <= ~rwn_q;
                  mem_wrn <= rwn_q;
                  state   <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (release_wr) mem_wrn <= 1'b1;
               if (release_cs) begin
                  mem_wrn <= 1'b1;
                  if (stretch_pend) begin
                     state <= STRETCH;
                  end else begin
                     ram_csn <= 1'b1;
                     rom_csn <= 1'b1;
                     io_csn  <= 1'b1;
                     mem_rdn <= 1'b1;
                     state   <= IDLE;
                     // Back-to-back: the next address rides the release edge.
                     if (latch_ad) begin
                        addr_q <= cpu_ab;
                        rwn_q  <= cpu_rwn;
                        state  <= ADDR;
                     end
                  end
               end
            end
            STRETCH: begin
               if (cnt_done) begin
                  ram_csn <= 1'b1;
                  rom_csn <= 1'b1;
                  io_csn  <= 1'b1;
                  mem_rdn <= 1'b1;
                  mem_wrn <= 1'b1;
                  state   <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 6: minimum IO stretch length in clk cycles.
REQ-002 SHALL have ports:
- clk  in  1  system clock, 48 MHz, 6x CPU clock.
- resetn  in  1  reset, synchronous, active-low.
- latch_ad  in  1  one-cycle strobe from phaser: capture address and rwn.
- setup_cs  in  1  one-cycle strobe: start chip-select phase.
- release_wr  in  1  one-cycle strobe: end write pulse.
- release_cs  in  1  one-cycle strobe: end access.
- stopped  in  1  phaser halted.
- run  out  1  phaser enable; 0 requests CPU stretch.
- cpu_ab  in  16  CPU address bus.
- cpu_rwn  in  1  CPU read=1, write=0.
- io_wait  in  1  slow IO device busy.
- ram_csn, rom_csn, io_csn  out  1 each  active-low selects.
- mem_rdn, mem_wrn  out  1 each  active-low strobes.

Function
REQ-003 SHALL register cpu_ab and cpu_rwn on the clk edge where latch_ad=1; no other cycle updates them.
REQ-004 SHALL decode the latched address: 0x0000-0x9EFF RAM, 0x9F00-0x9FFF IO, 0xA000-0xFFFF ROM; exactly one region per access.
REQ-005 SHALL implement FSM states IDLE, ADDR, ACTIVE, STRETCH, with transitions IDLE->ADDR on latch_ad, ADDR->ACTIVE on setup_cs, ACTIVE->IDLE on release_cs (non-stretched), ACTIVE->STRETCH on release_cs when stretch is pending, and STRETCH->IDLE when the stretch completes.
REQ-006 SHALL drive the selected csn low, and mem_rdn low if read, registered one cycle after the setup_cs edge.
REQ-007 SHALL drive mem_wrn low on the same cycle as csn for a write, and high one cycle after the release_wr edge, which is strictly before csn releases.
REQ-008 SHALL release all csn and mem_rdn (high) one cycle after the release_cs edge, unless stretching.
REQ-009 SHALL ignore setup_cs, release_wr and release_cs in IDLE, ignore latch_ad outside IDLE, and not advance state on those ignored strobes.
REQ-010 SHALL take IDLE->ADDR when latch_ad and release_cs coincide in ACTIVE: the access completes first, then the new address is captured on that edge.
REQ-011 SHALL force all csn/rdn/wrn high and return to IDLE whenever stopped=1 and the state is not STRETCH.
REQ-012 SHALL drive run=1 in all states except during an active stretch.
REQ-013 SHALL never assert more than one csn, nor mem_rdn and mem_wrn, simultaneously.

Reset
REQ-014 SHALL, when resetn=0 at a clk edge, set state IDLE, all csn/rdn/wrn=1, run=1, stretch counter=0, latched address=0x0000, latched rwn=1; an access in progress is aborted without glitch.

Configuration
REQ-015 With IO_WAIT_EN defined, an IO access SHALL:
- load the counter with WAIT_CYCLES and drive run=0 at setup_cs;
- decrement the counter each cycle to 0;
- defer the release_cs effect: csn/rdn stay low in STRETCH until counter=0 and io_wait=0;
- then release csn/rdn and drive run=1 in the same cycle, and go to IDLE.
REQ-016 Without IO_WAIT_EN, SHALL tie run=1 and ignore io_wait; IO accesses then time exactly like RAM, with no counter logic synthesized.

Structure
REQ-017 SHALL place the region enum (RAM, ROM, IO), region boundary constants and the WAIT_CYCLES default in package nora_bus_pkg.
REQ-018 SHALL implement the decode as combinational sub-module cpubus_addr_dec (16-bit address in, region out).

Verification
REQ-019 Bench SHALL drive the strobe sequence latch_ad, setup_cs (+1), release_wr (+3), release_cs (+5), at 6-cycle spacing, and cover:
- Read 0x1234: ram_csn and mem_rdn low from setup_cs+1 through release_cs; other selects high.
- Write 0xC000: rom_csn low; mem_wrn rises 1 cycle after release_wr, at least 2 cycles before rom_csn rises.
- IO read 0x9F10 with IO_WAIT_EN, WAIT_CYCLES=6, io_wait high 10 cycles: run=0 and io_csn held low until io_wait falls; then release and run=1 in the same cycle.
- Same IO access without IO_WAIT_EN: run constantly 1; io_csn timing identical to a RAM access.
- resetn=0 mid-write at 0x0200: next edge all csn/rdn/wrn high, run=1, state IDLE; the subsequent read of 0x0200 is normal.
- Boundaries 0x9EFF/0x9F00/0x9FFF/0xA000 map to RAM/IO/IO/ROM; stopped=1 during ACTIVE forces all selects high.
